// File: rtl/router_pkg.sv
// Shared types and constants for the credit-based router: flit type, input-buffer
// FSM states and port indices.
package router_pkg;

    localparam int unsigned DEFAULT_FLIT_WIDTH = 16;

    typedef logic [DEFAULT_FLIT_WIDTH-1:0] regflit;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_SEND_HDR,
        S_SIZE,
        S_PAYLOAD,
        S_END
    } buf_state_e;

    localparam int unsigned EAST  = 0;
    localparam int unsigned WEST  = 1;
    localparam int unsigned NORTH = 2;
    localparam int unsigned SOUTH = 3;
    localparam int unsigned LOCAL = 4;
    localparam int unsigned NPORT = 5;

endpackage

// File: rtl/router_if.sv
// Input-port bundle: upstream flit/credit handshake plus the switch-control and
// crossbar side. The slave modport is the buffer's view.
interface router_if
    import router_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = DEFAULT_FLIT_WIDTH
) ();

    logic                  rx;
    logic [FLIT_WIDTH-1:0] data_in;
    logic                  credit_o;
    logic                  h;
    logic                  ack_h;
    logic                  data_av;
    logic [FLIT_WIDTH-1:0] data;
    logic                  data_ack;
    logic                  sender;

    modport master (
        output rx, data_in, ack_h, data_ack,
        input  credit_o, h, data_av, data, sender
    );

    modport slave (
        input  rx, data_in, ack_h, data_ack,
        output credit_o, h, data_av, data, sender
    );

endinterface

// File: rtl/router_fifo.sv
// Circular flit FIFO with first-word fall-through read and a credit output.
// DEPTH must be a power of two and at least 4.
module router_fifo #(
    parameter int unsigned FLIT_WIDTH = 16,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_i,
    input  logic [FLIT_WIDTH-1:0] wdata_i,
    input  logic                  rd_i,
    output logic [FLIT_WIDTH-1:0] rdata_o,
    output logic                  credit_o,
    output logic                  not_empty_o
);

    localparam int unsigned    PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
    logic [FLIT_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  wr_en, rd_en;

    // Full/empty come from the count so pointer wrap never aliases the two.
    always_comb begin
        credit_o    = (count_q != FULL_CNT);
        not_empty_o = (count_q != '0);
        wr_en       = wr_i && credit_o;
        rd_en       = rd_i && not_empty_o;
        rdata_o     = mem_q[rd_ptr_q];
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/router_input_buffer.sv
// Router input buffer: FIFO plus packet FSM that requests routing per header and
// streams header, size and payload. Optional ROUTER_BUF_OVERFLOW_FLAG_EN adds overflow_o.
module router_input_buffer
    import router_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = DEFAULT_FLIT_WIDTH,
    parameter int unsigned DEPTH      = 16
) (
    input  logic    clock,
    input  logic    reset,
    router_if.slave bus
`ifdef ROUTER_BUF_OVERFLOW_FLAG_EN
    ,
    output logic    overflow_o
`endif
);

    localparam logic [FLIT_WIDTH-1:0] CNT_ONE = 1;

    buf_state_e            state_q, state_d;
    logic [FLIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [FLIT_WIDTH-1:0] fifo_rdata;
    logic                  fifo_credit, fifo_not_empty;
    logic                  rd_en, h, data_av, sender;

    router_fifo #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .wr_i        (bus.rx),
        .wdata_i     (bus.data_in),
        .rd_i        (rd_en),
        .rdata_o     (fifo_rdata),
        .credit_o    (fifo_credit),
        .not_empty_o (fifo_not_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE:     if (fifo_not_empty) state_d = S_HEADER;
            S_HEADER:   if (bus.ack_h) state_d = S_SEND_HDR;
            S_SEND_HDR: if (rd_en) state_d = S_SIZE;
            S_SIZE: begin
                if (rd_en) begin
                    cnt_d   = fifo_rdata;
                    state_d = (fifo_rdata == '0) ? S_END : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (rd_en) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = S_END;
                end
            end
            S_END:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // An empty FIFO mid-packet only drops data_av; the connection is kept.
    always_comb begin
        h       = 1'b0;
        data_av = 1'b0;
        sender  = 1'b0;
        unique case (state_q)
            S_HEADER: h = 1'b1;
            S_SEND_HDR, S_SIZE, S_PAYLOAD: begin
                data_av = fifo_not_empty;
                sender  = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd_en        = data_av && bus.data_ack;
    assign bus.credit_o = fifo_credit;
    assign bus.h        = h;
    assign bus.data_av  = data_av;
    assign bus.data     = fifo_rdata;
    assign bus.sender   = sender;

`ifdef ROUTER_BUF_OVERFLOW_FLAG_EN
    logic overflow_q, overflow_d;

    assign overflow_d = overflow_q || (bus.rx && !fifo_credit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_router_input_buffer.sv
// Directed self-checking bench for router_input_buffer; overflow checks only when
// ROUTER_BUF_OVERFLOW_FLAG_EN is defined.
module tb_router_input_buffer;
    import router_pkg::*;

    logic   clock;
    logic   reset;
    int     checks;
    int     failures;
    regflit pkt[$];

    router_if #(.FLIT_WIDTH(16)) bus ();

`ifdef ROUTER_BUF_OVERFLOW_FLAG_EN
    logic overflow_o;
`endif

    router_input_buffer #(
        .FLIT_WIDTH (16),
        .DEPTH      (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus)
`ifdef ROUTER_BUF_OVERFLOW_FLAG_EN
        ,
        .overflow_o (overflow_o)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rx       = 1'b0;
        bus.data_in  = '0;
        bus.ack_h    = 1'b0;
        bus.data_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Writes pkt whenever credit allows while the crossbar side reads; every read is checked.
    task automatic stream(input string tag, input bit toggle);
        int wr_idx  = 0;
        int rd_idx  = 0;
        int cyc     = 0;
        int max_cnt = 0;
        bus.data_ack = 1'b0;
        while (rd_idx < pkt.size() && cyc < 1000) begin
            bus.rx       = bus.credit_o && (wr_idx < pkt.size());
            bus.data_in  = bus.rx ? pkt[wr_idx] : '0;
            if (bus.rx) wr_idx++;
            bus.data_ack = toggle ? ~bus.data_ack : 1'b1;
            bus.ack_h    = bus.h;
            if (bus.data_av && bus.data_ack) begin
                check_eq($sformatf("%s_flit%0d", tag, rd_idx), 32'(bus.data), 32'(pkt[rd_idx]));
                rd_idx++;
            end
            tick();
            cyc++;
            if (int'(dut.u_fifo.count_q) > max_cnt) max_cnt = int'(dut.u_fifo.count_q);
        end
        idle_inputs();
        check_eq({tag, "_all_read"}, rd_idx, pkt.size());
        check_eq({tag, "_count_le_depth"}, 32'(max_cnt <= 16), 1);
        check_eq({tag, "_sender_low_at_end"}, bus.sender, 0);
        tick();
        check_eq({tag, "_back_idle"}, dut.state_q, S_IDLE);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();

        // Reset values while reset is held
        reset = 1'b1;
        #1;
        check_eq("rst_credit", bus.credit_o, 1);
        check_eq("rst_h", bus.h, 0);
        check_eq("rst_data_av", bus.data_av, 0);
        check_eq("rst_sender", bus.sender, 0);
        check_eq("rst_data", bus.data, 0);
`ifdef ROUTER_BUF_OVERFLOW_FLAG_EN
        check_eq("rst_overflow", overflow_o, 0);
`endif
        tick();
        reset = 1'b0;
        tick();

        // Single packet, ack_h two cycles after h
        bus.data_ack = 1'b1;
        bus.rx = 1'b1; bus.data_in = 16'h0011; tick();
        check_eq("p1_h_not_yet", bus.h, 0);
        bus.data_in = 16'h0002; tick();
        check_eq("p1_h_up", bus.h, 1);
        check_eq("p1_no_av_before_ack", bus.data_av, 0);
        check_eq("p1_sender_before_ack", bus.sender, 0);
        check_eq("p1_fwft_head", bus.data, 16'h0011);
        bus.data_in = 16'hAAAA; tick();
        check_eq("p1_h_held", bus.h, 1);
        bus.data_in = 16'hBBBB; bus.ack_h = 1'b1; tick();
        bus.rx = 1'b0; bus.ack_h = 1'b0;
        check_eq("p1_sender_at_ack", bus.sender, 1);
        check_eq("p1_h_dropped", bus.h, 0);
        check_eq("p1_av_hdr", bus.data_av, 1);
        check_eq("p1_data_hdr", bus.data, 16'h0011);
        tick();
        check_eq("p1_data_size", bus.data, 16'h0002);
        tick();
        check_eq("p1_data_pay0", bus.data, 16'hAAAA);
        check_eq("p1_sender_pay0", bus.sender, 1);
        tick();
        check_eq("p1_data_pay1", bus.data, 16'hBBBB);
        check_eq("p1_sender_pay1", bus.sender, 1);
        tick();
        check_eq("p1_sender_end", bus.sender, 0);
        check_eq("p1_av_end", bus.data_av, 0);
        check_eq("p1_state_end", dut.state_q, S_END);
        tick();
        check_eq("p1_state_idle", dut.state_q, S_IDLE);
        check_eq("p1_h_idle", bus.h, 0);

        // Zero payload, then a fresh header re-raises h
        do_reset();
        bus.data_ack = 1'b1;
        bus.rx = 1'b1; bus.data_in = 16'h0022; tick();
        bus.data_in = 16'h0000; tick();
        bus.rx = 1'b0;
        check_eq("zp_h_up", bus.h, 1);
        bus.ack_h = 1'b1; tick();
        bus.ack_h = 1'b0;
        check_eq("zp_data_hdr", bus.data, 16'h0022);
        check_eq("zp_sender", bus.sender, 1);
        tick();
        check_eq("zp_data_size", bus.data, 16'h0000);
        check_eq("zp_state_size", dut.state_q, S_SIZE);
        tick();
        check_eq("zp_state_end", dut.state_q, S_END);
        check_eq("zp_fifo_empty", dut.u_fifo.count_q, 0);
        check_eq("zp_sender_end", bus.sender, 0);
        tick();
        check_eq("zp_idle_h", bus.h, 0);
        bus.rx = 1'b1; bus.data_in = 16'h0033; tick();
        bus.rx = 1'b0;
        check_eq("zp_next_h_wait", bus.h, 0);
        tick();
        check_eq("zp_next_h_up", bus.h, 1);

        // Full: 16 writes fill, the 17th is dropped
        do_reset();
        bus.rx = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.data_in = 16'(16'h0100 + i);
            tick();
            if (i == 14) check_eq("full_credit_at_15", bus.credit_o, 1);
        end
        check_eq("full_credit_at_16", bus.credit_o, 0);
`ifdef ROUTER_BUF_OVERFLOW_FLAG_EN
        check_eq("full_no_overflow_yet", overflow_o, 0);
`endif
        bus.data_in = 16'hDEAD; tick();
        bus.rx = 1'b0;
        check_eq("full_credit_after_17", bus.credit_o, 0);
`ifdef ROUTER_BUF_OVERFLOW_FLAG_EN
        check_eq("full_overflow_set", overflow_o, 1);
        tick();
        check_eq("full_overflow_sticky", overflow_o, 1);
`endif
        bus.ack_h = 1'b1; tick();
        bus.ack_h = 1'b0; bus.data_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("full_drain%0d", i), bus.data, 16'(16'h0100 + i));
            tick();
        end
        check_eq("full_17th_dropped", bus.data_av, 0);
        check_eq("full_sender_held", bus.sender, 1);

        // Wrap-around with data_ack toggling
        do_reset();
        pkt = {};
        pkt.push_back(16'h0044);
        pkt.push_back(16'd38);
        for (int k = 0; k < 38; k++) pkt.push_back(16'(16'h5000 + k));
        stream("wrap", 1'b1);

        // Starvation between size and payload
        do_reset();
        bus.data_ack = 1'b1;
        bus.rx = 1'b1; bus.data_in = 16'h0055; tick();
        bus.data_in = 16'h0003; tick();
        bus.rx = 1'b0; bus.ack_h = 1'b1; tick();
        bus.ack_h = 1'b0;
        check_eq("stv_data_hdr", bus.data, 16'h0055);
        tick();
        check_eq("stv_data_size", bus.data, 16'h0003);
        tick();
        for (int c = 0; c < 10; c++) tick();
        check_eq("stv_av_low", bus.data_av, 0);
        check_eq("stv_sender_held", bus.sender, 1);
        check_eq("stv_state_payload", dut.state_q, S_PAYLOAD);
        for (int k = 0; k < 3; k++) begin
            bus.rx = 1'b1; bus.data_in = 16'(16'h6000 + k); tick();
            check_eq($sformatf("stv_pay%0d", k), bus.data, 16'(16'h6000 + k));
            check_eq($sformatf("stv_av%0d", k), bus.data_av, 1);
        end
        bus.rx = 1'b0; tick();
        check_eq("stv_sender_end", bus.sender, 0);
        check_eq("stv_state_end", dut.state_q, S_END);

        // Reset asserted during payload, then a normal packet
        do_reset();
        bus.data_ack = 1'b1; bus.ack_h = 1'b1;
        bus.rx = 1'b1; bus.data_in = 16'h0066; tick();
        bus.data_in = 16'h0005; tick();
        bus.data_in = 16'h6600; tick();
        bus.data_in = 16'h6601; tick();
        bus.rx = 1'b0; tick();
        bus.ack_h = 1'b0;
        check_eq("mr_in_payload", dut.state_q, S_PAYLOAD);
        check_eq("mr_sender_before", bus.sender, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mr_credit", bus.credit_o, 1);
        check_eq("mr_h", bus.h, 0);
        check_eq("mr_data_av", bus.data_av, 0);
        check_eq("mr_sender", bus.sender, 0);
        check_eq("mr_data", bus.data, 0);
        reset = 1'b0;
        tick();
        pkt = {};
        pkt.push_back(16'h0077);
        pkt.push_back(16'h0001);
        pkt.push_back(16'h7000);
        stream("mr_next", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
